uart_tx_scheduler: RTL and testbench

// - Shares one uart_transmitter among N_REQ byte requesters with round-robin fairness.
// - Latches the granted byte, drives Tx_DATA/Tx_WR/TX_EN and sequences the frame via TX_BUSY.
// - Reports accept/done per requester; recovers if the transmitter never starts.
// - Sits between client logic and uart_transmitter; baud_select passes through unchanged.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 123 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared scheduler state type, baud codes and round-robin helper
package uart_pkg;

  typedef enum logic [1:0] {IDLE, STROBE, WAIT_START, WAIT_DONE} sched_state_t;

  localparam logic [2:0] BAUD_1200   = 3'b000;
  localparam logic [2:0] BAUD_2400   = 3'b001;
  localparam logic [2:0] BAUD_4800   = 3'b010;
  localparam logic [2:0] BAUD_9600   = 3'b011;
  localparam logic [2:0] BAUD_19200  = 3'b100;
  localparam logic [2:0] BAUD_38400  = 3'b101;
  localparam logic [2:0] BAUD_57600  = 3'b110;
  localparam logic [2:0] BAUD_115200 = 3'b111;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at/after pointer
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  int j;

  // Scan from farthest to nearest so the last hit is the one closest to pointer.
  always_comb begin
    grant = '0;
    index = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(pointer) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        index    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one uart_transmitter among byte requesters
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int START_TMO = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   req_done,
  output logic [N_REQ-1:0]   req_err,
  input  logic               sched_en,
  input  logic [2:0]         baud_in,
  output logic [7:0]         Tx_DATA,
  output logic               Tx_WR,
  output logic               TX_EN,
  output logic [2:0]         baud_select,
  input  logic               TX_BUSY,
  output logic               sched_busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (START_TMO > 1) ? $clog2(START_TMO) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(START_TMO - 1);

  sched_state_t     state, state_d;
  logic [IW-1:0]    ptr, ptr_d, owner, owner_d, owner_next, gnt_idx;
  logic [N_REQ-1:0] gnt, ack_d, done_d, err_d;
  logic [7:0]       data_d;
  logic             wr_d;
  logic [CW-1:0]    cnt, cnt_d;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .pointer (ptr),
    .grant   (gnt),
    .index   (gnt_idx)
  );

  assign owner_next  = IW'(rr_next(int'(owner), N_REQ));
  assign baud_select = baud_in;
  assign sched_busy  = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // All strobes are registered so reset forces them low without combinational glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Tx_DATA  <= 8'h00;
      Tx_WR    <= 1'b0;
      TX_EN    <= 1'b0;
      req_ack  <= '0;
      req_done <= '0;
      req_err  <= '0;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
    end else begin
      Tx_DATA  <= data_d;
      Tx_WR    <= wr_d;
      TX_EN    <= 1'b1;
      req_ack  <= ack_d;
      req_done <= done_d;
      req_err  <= err_d;
      ptr      <= ptr_d;
      owner    <= owner_d;
      cnt      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    data_d  = Tx_DATA;
    wr_d    = 1'b0;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    ptr_d   = ptr;
    owner_d = owner;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (sched_en && (|req_valid) && !TX_BUSY) begin
          data_d  = req_data[8*gnt_idx +: 8];
          owner_d = gnt_idx;
          ack_d   = gnt;
          state_d = STROBE;
        end
      end
      STROBE: begin
        wr_d    = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (TX_BUSY) begin
          state_d = WAIT_DONE;
        end else if (cnt == TMO_LAST) begin
          err_d[owner] = 1'b1;
          ptr_d        = owner_next;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          done_d[owner] = 1'b1;
          ptr_d         = owner_next;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ack, req_done, req_err;
  logic           sched_en;
  logic [2:0]     baud_in, baud_select;
  logic [7:0]     Tx_DATA;
  logic           Tx_WR, TX_EN, TX_BUSY, sched_busy;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.N_REQ(N), .START_TMO(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .req_done(req_done), .req_err(req_err), .sched_en(sched_en),
    .baud_in(baud_in), .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .TX_EN(TX_EN),
    .baud_select(baud_select), .TX_BUSY(TX_BUSY), .sched_busy(sched_busy)
  );

  typedef struct {
    logic [N-1:0]   valid;
    logic [8*N-1:0] data;
    logic [2:0]     baud;
    int             exp_idx;
    logic [7:0]     exp_byte;
  } vec_t;

  int checks = 0, failures = 0;
  bit sb_en = 0;
  int m_phase = 0, m_ptr = 0, m_owner = 0, m_wait = 0;
  logic [7:0] m_byte = 8'h00;
  int grant_log[$];
  logic [N-1:0] last_ack = '0, drop_mask = '0;
  int stub_mode = 0, stub_state = 0, stub_cnt = 0, stub_delay = 0, stub_len = 2;
  int n_ack = 0, n_term = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // Transaction-level reference: grant, strobe, wait for start (or time out), wait for end.
  task automatic scoreboard();
    logic [N-1:0] ea, ed, ee;
    logic ew;
    ea = '0; ed = '0; ee = '0; ew = 1'b0;
    case (m_phase)
      0: if (sched_en && req_valid != 0 && !TX_BUSY) begin
           m_owner = pick(req_valid, m_ptr);
           ea[m_owner] = 1'b1;
           m_byte = req_data[8*m_owner +: 8];
           m_phase = 1;
         end
      1: begin ew = 1'b1; m_phase = 2; m_wait = 0; end
      2: if (TX_BUSY) m_phase = 3;
         else begin
           m_wait++;
           if (m_wait == TMO) begin
             ee[m_owner] = 1'b1; m_ptr = (m_owner + 1) % N; m_phase = 0;
           end
         end
      default: if (!TX_BUSY) begin
           ed[m_owner] = 1'b1; m_ptr = (m_owner + 1) % N; m_phase = 0;
         end
    endcase
    check("sb_ack", req_ack, ea);
    check("sb_wr", Tx_WR, ew);
    if (ew) check("sb_data", Tx_DATA, m_byte);
    check("sb_done", req_done, ed);
    check("sb_err", req_err, ee);
    check("sb_busy", sched_busy, m_phase != 0);
    check("sb_baud", baud_select, baud_in);
    check("sb_txen", TX_EN, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    last_ack = req_ack;
    for (int i = 0; i < N; i++) if (req_ack[i]) grant_log.push_back(i);
    n_ack  += $countones(req_ack);
    n_term += $countones(req_done | req_err);
    if (sb_en) scoreboard();
    if (Tx_WR === 1'b1 && stub_mode == 0) begin stub_state = 1; stub_cnt = stub_delay; end
    @(negedge clk);
    if (stub_state == 1) begin
      if (stub_cnt == 0) begin TX_BUSY = 1'b1; stub_state = 2; stub_cnt = stub_len; end
      else stub_cnt--;
    end else if (stub_state == 2) begin
      if (stub_cnt == 0) begin TX_BUSY = 1'b0; stub_state = 0; end
      else stub_cnt--;
    end
  endtask

  task automatic run_acks(input int n);
    int got = 0;
    for (int b = 0; b < 600 && got < n; b++) begin
      tick();
      for (int i = 0; i < N; i++) if (last_ack[i]) begin
        got++;
        if (drop_mask[i]) req_valid[i] = 1'b0;
      end
    end
    check("ack_wait", got, n);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int b = 0; b < 300 && !idle; b++) begin
      tick();
      idle = (sched_busy == 1'b0);
    end
    check("idle_wait", idle, 1);
  endtask

  vec_t tbl[8];

  initial begin
    int base, n, ok;
    logic [N-1:0] acc;
    tbl[0] = '{4'b0001, 32'h000000DD, BAUD_115200, 0, 8'hDD};
    tbl[1] = '{4'b0001, 32'h0000005A, BAUD_1200,   0, 8'h5A};
    tbl[2] = '{4'b1001, 32'hC3000011, BAUD_2400,   3, 8'hC3};
    tbl[3] = '{4'b1110, 32'h77665500, BAUD_4800,   1, 8'h55};
    tbl[4] = '{4'b0011, 32'h00002A1B, BAUD_9600,   0, 8'h1B};
    tbl[5] = '{4'b0110, 32'h00E1F000, BAUD_19200,  1, 8'hF0};
    tbl[6] = '{4'b1111, 32'h81422418, BAUD_38400,  2, 8'h42};
    tbl[7] = '{4'b1111, 32'h81422418, BAUD_57600,  3, 8'h81};

    reset = 1'b0; req_valid = '0; req_data = '0; sched_en = 1'b1;
    baud_in = BAUD_9600; TX_BUSY = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_data", Tx_DATA, 8'h00);
    check("rst_wr", Tx_WR, 0);
    check("rst_txen", TX_EN, 0);
    check("rst_pulses", {req_ack, req_done, req_err}, 0);
    check("rst_busy", sched_busy, 0);
    reset = 1'b1; sb_en = 1;
    tick();
    check("txen_after_rst", TX_EN, 1);

    for (int t = 0; t < 8; t++) begin
      req_valid = tbl[t].valid; req_data = tbl[t].data; baud_in = tbl[t].baud;
      tick();
      check("tbl_ack", req_ack, 32'(1) << tbl[t].exp_idx);
      req_valid = '0;
      tick();
      check("tbl_wr", Tx_WR, 1);
      check("tbl_data", Tx_DATA, tbl[t].exp_byte);
      check("tbl_baud", baud_select, tbl[t].baud);
      ok = 0;
      for (int k = 0; k < 20 && ok == 0; k++) begin
        tick();
        if (req_done != 0) ok = 1;
      end
      check("tbl_done", req_done, 32'(1) << tbl[t].exp_idx);
    end

    base = grant_log.size();
    req_data = 32'h44332211; req_valid = 4'b1111; drop_mask = 4'b1111;
    run_acks(4);
    wait_idle();
    check("all4_count", grant_log.size() - base, 4);
    for (int i = 0; i < 4; i++) check("all4_order", grant_log[base + i], i);

    base = grant_log.size();
    req_valid = 4'b0001; drop_mask = 4'b0100;
    run_acks(1);
    req_valid[2] = 1'b1;
    run_acks(2);
    req_valid = '0;
    wait_idle();
    check("fair_0", grant_log[base], 0);
    check("fair_1", grant_log[base + 1], 2);
    check("fair_2", grant_log[base + 2], 0);

    stub_mode = 1; req_valid = 4'b0110; drop_mask = 4'b0110;
    run_acks(1);
    check("tmo_owner", grant_log[grant_log.size() - 1], 1);
    tick();
    check("tmo_wr", Tx_WR, 1);
    n = 0;
    for (int k = 0; k < 200 && req_err == 0; k++) begin tick(); n++; end
    check("tmo_cycles", n, TMO);
    check("tmo_err", req_err, 4'b0010);
    stub_mode = 0;
    run_acks(1);
    check("tmo_next", grant_log[grant_log.size() - 1], 2);
    req_valid = '0;
    wait_idle();

    req_valid = 4'b1001; drop_mask = '0;
    run_acks(1);
    check("en_owner", grant_log[grant_log.size() - 1], 3);
    req_valid[3] = 1'b0;
    tick();
    sched_en = 1'b0;
    ok = 0;
    for (int k = 0; k < 30 && ok == 0; k++) begin tick(); if (req_done != 0) ok = 1; end
    check("en_done", req_done, 4'b1000);
    acc = '0;
    for (int k = 0; k < 8; k++) begin tick(); acc |= req_ack; end
    check("en_hold", acc, 0);
    sched_en = 1'b1;
    tick();
    check("en_resume", req_ack, 4'b0001);
    req_valid = '0;
    wait_idle();

    TX_BUSY = 1'b1; req_valid = 4'b0010;
    acc = '0;
    for (int k = 0; k < 5; k++) begin tick(); acc |= req_ack; end
    check("foreign_hold", acc, 0);
    TX_BUSY = 1'b0;
    tick();
    check("foreign_grant", req_ack, 4'b0010);
    req_valid = '0;
    wait_idle();

    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    wait_idle();
    stub_len = 8; req_valid = 4'b0100;
    tick();
    check("rmid_ack", req_ack, 4'b0100);
    req_valid = '0;
    tick();
    tick();
    check("rmid_busy", sched_busy, 1);
    reset = 1'b0; sb_en = 0;
    #1;
    check("rmid_wr", Tx_WR, 0);
    check("rmid_txen", TX_EN, 0);
    check("rmid_data", Tx_DATA, 8'h00);
    check("rmid_sbusy", sched_busy, 0);
    TX_BUSY = 1'b0; stub_state = 0; stub_len = 2;
    tick(); tick();
    reset = 1'b1; m_phase = 0; m_ptr = 0; sb_en = 1;
    req_valid = 4'b1010; drop_mask = 4'b1010;
    run_acks(1);
    check("rmid_ptr", grant_log[grant_log.size() - 1], 1);
    req_valid = '0;
    wait_idle();

    n_ack = 0; n_term = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (last_ack[i]) begin
          if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
          else req_data[8*i +: 8] = 8'($urandom);
        end else if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
          req_valid[i] = 1'b1; req_data[8*i +: 8] = 8'($urandom);
        end else if (req_valid[i] && $urandom_range(0, 40) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      sched_en = ($urandom_range(0, 9) != 0);
      baud_in = 3'($urandom);
      if (stub_state == 0) begin
        stub_mode  = ($urandom_range(0, 11) == 0) ? 1 : 0;
        stub_delay = $urandom_range(0, 3);
        stub_len   = $urandom_range(0, 5);
        if (!TX_BUSY && $urandom_range(0, 60) == 0) begin
          TX_BUSY = 1'b1; stub_state = 2; stub_cnt = 0;
        end
      end
    end
    req_valid = '0; sched_en = 1'b1; stub_mode = 0;
    wait_idle();
    check("frames_balanced", n_term, n_ack);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
